// File: rtl/ysyx_24100012_pkg.sv
// Shared types and constants for the ysyx_24100012 instruction fetch path.
// Holds the fetch FSM encoding and the architectural reset PC.
package ysyx_24100012_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_t;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100012_ifu.sv
// Instruction fetch unit: keeps the PC, issues one fetch at a time and hands the word to decode.
// Performance counters are built only when YSYX_24100012_IFU_PERF_EN is defined.
module ysyx_24100012_ifu
    import ysyx_24100012_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef YSYX_24100012_IFU_PERF_EN
    ,
    output logic [63:0]           perf_fetch_cnt,
    output logic [63:0]           perf_stall_cnt,
    output logic [63:0]           perf_flush_cnt
`endif
);

    ifu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  discard_q, discard_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;

    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ADDR_WIDTH-1:0] pc_next_seq;

    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign pc_next_seq     = pc_q + ADDR_WIDTH'(INST_BYTES);

    // Request is suppressed while reset is held so memory never sees a fetch during reset.
    assign mem_req_valid = (state_q == REQ) && !rst;
    assign mem_req_addr  = pc_q;
    assign out_valid     = (state_q == HOLD) && !redirect_valid;
    assign out_inst      = inst_q;
    assign out_pc        = opc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        opc_d     = opc_q;
        unique case (state_q)
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
                // A request accepted together with a redirect fetched the stale PC.
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (mem_req_ready) begin
                        discard_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (discard_q || redirect_valid) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        inst_d  = mem_resp_data;
                        opc_d   = pc_q;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (out_ready) begin
                    pc_d    = pc_next_seq;
                    state_d = REQ;
                end
            end
            default: begin
                state_d   = REQ;
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            inst_q    <= '0;
            opc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
            opc_q     <= opc_d;
        end
    end

`ifdef YSYX_24100012_IFU_PERF_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;
    logic [63:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 64'(out_valid && out_ready);
        stall_cnt_d = stall_cnt_q
                    + 64'((state_q == WAIT) || ((state_q == HOLD) && !out_ready));
        flush_cnt_d = flush_cnt_q + 64'(redirect_valid && (state_q != REQ));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    // Memory must only answer while a fetch is outstanding; stray responses are dropped.
    a_resp_only_in_wait : assert property (
        @(posedge clk) disable iff (rst) mem_resp_valid |-> (state_q == WAIT)
    );

    a_hold_stable : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == HOLD) && !redirect_valid && !out_ready |=> $stable(inst_q) && $stable(opc_q)
    );

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// Randomized bench for ysyx_24100012_ifu against a transaction-level fetch model.
// Perf counter ports are connected and checked when YSYX_24100012_IFU_PERF_EN is defined.
module tb_ysyx_24100012_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef YSYX_24100012_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
    logic [63:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_24100012_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef YSYX_24100012_IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected fetch PC, whether a word is waiting for decode,
    // whether a fetch is outstanding and whether its answer has been redirected away.
    logic [31:0] m_pc;
    logic        m_have;
    logic [31:0] m_inst;
    logic        m_outst;
    logic        m_stale;
    logic [63:0] m_fetch, m_stall, m_flush;

    // Memory model: one pending answer with a countdown.
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;

    int          rdy_pct, ord_pct, redir_pct, min_lat, max_lat;
    logic        use_fixed;
    logic [31:0] fixed_data;
    int          obs_hs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_have   = 1'b0;
        m_inst   = '0;
        m_outst  = 1'b0;
        m_stale  = 1'b0;
        m_fetch  = '0;
        m_stall  = '0;
        m_flush  = '0;
        mem_pend = 1'b0;
        mem_cnt  = 0;
        mem_data = '0;
    endtask

    task automatic drive_idle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
    endtask

    task automatic drive_inputs();
        mem_req_ready  = ($urandom_range(99) < rdy_pct);
        out_ready      = ($urandom_range(99) < ord_pct);
        redirect_valid = ($urandom_range(99) < redir_pct);
        redirect_pc    = $urandom;
        mem_resp_valid = mem_pend && (mem_cnt == 0);
        mem_resp_data  = mem_resp_valid ? mem_data : $urandom;
    endtask

    // Check outputs mid-cycle, then advance model and memory across the next edge.
    task automatic cycle();
        logic acc, hs, rsp;
        @(negedge clk);
        check("req_valid", 64'(mem_req_valid), 64'(!m_outst && !m_have));
        if (mem_req_valid) check("req_addr", 64'(mem_req_addr), 64'(m_pc));
        check("out_valid", 64'(out_valid), 64'(m_have && !redirect_valid));
        if (m_have) begin
            check("out_pc", 64'(out_pc), 64'(m_pc));
            check("out_inst", 64'(out_inst), 64'(m_inst));
        end
        if (out_valid && out_ready) obs_hs++;

        acc = !m_outst && !m_have && mem_req_ready;
        hs  = m_have && !redirect_valid && out_ready;
        rsp = mem_resp_valid;

        if (hs) m_fetch++;
        if (m_outst || (m_have && !out_ready)) m_stall++;
        if (redirect_valid && (m_outst || m_have)) m_flush++;

        if (rsp) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (acc) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(max_lat, min_lat);
            mem_data = use_fixed ? fixed_data : $urandom;
        end

        if (rsp) begin
            m_outst = 1'b0;
            if (!m_stale && !redirect_valid) begin
                m_have = 1'b1;
                m_inst = mem_resp_data;
            end
            m_stale = 1'b0;
        end else if (redirect_valid && m_outst) begin
            m_stale = 1'b1;
        end
        if (acc) begin
            m_outst = 1'b1;
            m_stale = redirect_valid;
        end
        if (redirect_valid) begin
            m_pc   = redirect_pc & ~32'd3;
            m_have = 1'b0;
        end else if (hs) begin
            m_pc   = m_pc + 32'd4;
            m_have = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            cycle();
        end
    endtask

    task automatic set_mode(input int rdy, input int ord, input int redir, input int lo, input int hi);
        rdy_pct   = rdy;
        ord_pct   = ord;
        redir_pct = redir;
        min_lat   = lo;
        max_lat   = hi;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        drive_idle();
        model_reset();
        use_fixed  = 1'b1;
        fixed_data = 32'h0000_0413;
        obs_hs     = 0;
        #1;
        check("rst_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_inst", 64'(out_inst), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        #21 rst = 1'b0;
        @(posedge clk);
        #1;

        // Steady fetch: always ready, one-cycle memory, three words in nine cycles.
        set_mode(100, 100, 0, 0, 0);
        drive_inputs();
        @(negedge clk);
        check("first_addr", 64'(mem_req_addr), 64'(32'h8000_0000));
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        obs_hs = 0;
        run_random(9);
        check("throughput_9cyc", 64'(obs_hs), 64'(3));

        // Backpressure: decode stalls for five cycles with a word held.
        set_mode(100, 0, 0, 0, 1);
        for (int i = 0; i < 20 && !m_have; i++) begin drive_inputs(); cycle(); end
        check("reach_hold_bp", 64'(m_have), 64'(1));
        run_random(5);
        check("bp_still_valid", 64'(out_valid), 64'(1));
        ord_pct = 100;
        run_random(3);

        // Redirect while waiting on a slow response that carries DEADBEEF.
        fixed_data = 32'hDEAD_BEEF;
        set_mode(100, 100, 0, 2, 2);
        for (int i = 0; i < 20 && !m_outst; i++) begin drive_inputs(); cycle(); end
        check("reach_wait", 64'(m_outst), 64'(1));
        drive_inputs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        cycle();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive_inputs();
            if (mem_req_valid) begin
                seen = 1'b1;
                check("redir_wait_addr", 64'(mem_req_addr), 64'(32'h8000_1000));
            end
            cycle();
        end
        check("redir_wait_req_seen", 64'(seen), 64'(1));

        // Redirect in HOLD with decode ready in the same cycle.
        use_fixed = 1'b0;
        set_mode(100, 0, 0, 0, 1);
        for (int i = 0; i < 20 && !m_have; i++) begin drive_inputs(); cycle(); end
        check("reach_hold_redir", 64'(m_have), 64'(1));
        drive_inputs();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        cycle();
        set_mode(100, 100, 0, 0, 1);
        run_random(4);

        // Redirect coincident with the response.
        set_mode(100, 100, 0, 1, 3);
        for (int i = 0; i < 30 && !(mem_pend && mem_cnt == 0); i++) begin drive_inputs(); cycle(); end
        check("reach_resp", 64'(mem_pend && mem_cnt == 0), 64'(1));
        drive_inputs();
        redirect_valid = 1'b1;
        cycle();
        run_random(6);

        // Long randomized run.
        set_mode(70, 60, 10, 0, 3);
        run_random(3000);

        // Asynchronous reset in the middle of a fetch.
        set_mode(100, 100, 0, 3, 3);
        for (int i = 0; i < 20 && !m_outst; i++) begin drive_inputs(); cycle(); end
        check("reach_wait_rst", 64'(m_outst), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        drive_idle();
        #1;
        check("arst_req_valid", 64'(mem_req_valid), 64'(0));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_inst", 64'(out_inst), 64'(0));
        check("arst_out_pc", 64'(out_pc), 64'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        set_mode(100, 100, 0, 0, 0);
        drive_inputs();
        @(negedge clk);
        check("arst_first_addr", 64'(mem_req_addr), 64'(32'h8000_0000));
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;

        set_mode(70, 60, 10, 0, 3);
        run_random(600);

`ifdef YSYX_24100012_IFU_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_stall", perf_stall_cnt, m_stall);
        check("perf_flush", perf_flush_cnt, m_flush);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
